// File: rtl/unpooling_stream_if.sv
// Stream bundle for unpooling_stream: low-resolution raster in, upscaled raster out.
// The in_index signal exists only when UNPOOL_INDEX_EN is defined.
interface unpooling_stream_if #(
    parameter int IN_WIDTH   = 320,
    parameter int IN_HEIGHT  = 240,
    parameter int FIXED_BITW = 16,
    parameter int UNITS      = 8,
    parameter int SCALE_LOG2 = 1
);
    localparam int SCALE  = 1 << SCALE_LOG2;
    localparam int PIX_W  = FIXED_BITW * UNITS;
    localparam int V_BITW = $clog2(IN_HEIGHT * SCALE);
    localparam int H_BITW = $clog2(IN_WIDTH * SCALE);

    logic              in_enable;
    logic              in_ready;
    logic [PIX_W-1:0]  in_pixels;
    logic              out_enable;
    logic [PIX_W-1:0]  out_pixels;
    logic [V_BITW-1:0] out_vcnt;
    logic [H_BITW-1:0] out_hcnt;
    logic              out_frame_end;

`ifdef UNPOOL_INDEX_EN
    logic [2*SCALE_LOG2-1:0] in_index;

    modport master (
        output in_enable, in_pixels, in_index,
        input  in_ready, out_enable, out_pixels, out_vcnt, out_hcnt, out_frame_end
    );
    modport slave (
        input  in_enable, in_pixels, in_index,
        output in_ready, out_enable, out_pixels, out_vcnt, out_hcnt, out_frame_end
    );
`else
    modport master (
        output in_enable, in_pixels,
        input  in_ready, out_enable, out_pixels, out_vcnt, out_hcnt, out_frame_end
    );
    modport slave (
        input  in_enable, in_pixels,
        output in_ready, out_enable, out_pixels, out_vcnt, out_hcnt, out_frame_end
    );
`endif
endinterface

// File: rtl/unpooling_stream.sv
// Streaming 2^SCALE_LOG2 unpooling (replicate or zero-insert) over a ping-pong line buffer.
// Optional UNPOOL_INDEX_EN: store per-pixel switch indices and place each value at its index (max-unpooling).
module unpooling_stream #(
    parameter int IN_WIDTH   = 320,
    parameter int IN_HEIGHT  = 240,
    parameter int FIXED_BITW = 16,
    parameter int UNITS      = 8,
    parameter int SCALE_LOG2 = 1,
    parameter int MODE       = 0
) (
    input  logic              clock,
    input  logic              n_rst,
    unpooling_stream_if.slave stream
);
    localparam int SCALE  = 1 << SCALE_LOG2;
    localparam int PIX_W  = FIXED_BITW * UNITS;
    localparam int IDX_W  = 2 * SCALE_LOG2;
`ifdef UNPOOL_INDEX_EN
    localparam int WORD_W = PIX_W + IDX_W;
`else
    localparam int WORD_W = PIX_W;
`endif
    localparam int COL_W  = $clog2(IN_WIDTH);
    localparam int ROW_W  = $clog2(IN_HEIGHT);
    localparam int V_BITW = $clog2(IN_HEIGHT * SCALE);
    localparam int H_BITW = $clog2(IN_WIDTH * SCALE);

    localparam logic [COL_W-1:0]      COL_LAST = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(IN_HEIGHT - 1);
    localparam logic [SCALE_LOG2-1:0] SUB_LAST = {SCALE_LOG2{1'b1}};
    localparam logic [SCALE_LOG2-1:0] SUB_ZERO = {SCALE_LOG2{1'b0}};
    localparam logic [PIX_W-1:0]      PIX_ZERO = {PIX_W{1'b0}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } rd_state_t;

    logic [WORD_W-1:0]     mem_r [0:1][0:IN_WIDTH-1];
    logic [ROW_W-1:0]      row_tag_r [0:1];
    logic [1:0]            full_r;
    logic                  wr_sel_r;
    logic [COL_W-1:0]      wr_col_r;
    logic [ROW_W-1:0]      in_row_r;

    rd_state_t             state_r;
    logic                  rd_sel_r;
    logic [SCALE_LOG2-1:0] sub_h_r;
    logic [SCALE_LOG2-1:0] sub_v_r;
    logic [COL_W-1:0]      col_r;

    logic                  out_enable_r;
    logic [PIX_W-1:0]      out_pixels_r;
    logic [V_BITW-1:0]     out_vcnt_r;
    logic [H_BITW-1:0]     out_hcnt_r;
    logic                  out_frame_end_r;

    logic                  in_ready_s;
    logic                  accept_s;
    logic                  line_done_s;
    logic                  last_pix_s;
    logic [1:0]            set_mask_s;
    logic [1:0]            clr_mask_s;
    logic [WORD_W-1:0]     in_word_s;
    logic [WORD_W-1:0]     rd_word_s;
    logic [PIX_W-1:0]      out_val_s;

    assign in_ready_s           = n_rst & ~full_r[wr_sel_r];
    assign stream.in_ready      = in_ready_s;
    assign stream.out_enable    = out_enable_r;
    assign stream.out_pixels    = out_pixels_r;
    assign stream.out_vcnt      = out_vcnt_r;
    assign stream.out_hcnt      = out_hcnt_r;
    assign stream.out_frame_end = out_frame_end_r;

    // Handshake, line completion and bank flag set/clear requests.
    always_comb begin
        accept_s    = stream.in_enable & in_ready_s;
        line_done_s = accept_s & (wr_col_r == COL_LAST);
        last_pix_s  = (state_r == ST_RUN) & (sub_h_r == SUB_LAST) &
                      (col_r == COL_LAST) & (sub_v_r == SUB_LAST);
        set_mask_s  = 2'b00;
        clr_mask_s  = 2'b00;
        if (line_done_s) begin
            set_mask_s = 2'b01 << wr_sel_r;
        end else begin
            set_mask_s = 2'b00;
        end
        if (last_pix_s) begin
            clr_mask_s = 2'b01 << rd_sel_r;
        end else begin
            clr_mask_s = 2'b00;
        end
`ifdef UNPOOL_INDEX_EN
        in_word_s = {stream.in_index, stream.in_pixels};
`else
        in_word_s = stream.in_pixels;
`endif
    end

    // Select the value for the current sub-pixel position of the block.
    always_comb begin
        rd_word_s = mem_r[rd_sel_r][col_r];
        out_val_s = PIX_ZERO;
`ifdef UNPOOL_INDEX_EN
        if ((sub_v_r == rd_word_s[WORD_W-1 -: SCALE_LOG2]) &&
            (sub_h_r == rd_word_s[PIX_W +: SCALE_LOG2])) begin
            out_val_s = rd_word_s[PIX_W-1:0];
        end else begin
            out_val_s = PIX_ZERO;
        end
`else
        if ((MODE == 0) || ((sub_v_r == SUB_ZERO) && (sub_h_r == SUB_ZERO))) begin
            out_val_s = rd_word_s;
        end else begin
            out_val_s = PIX_ZERO;
        end
`endif
    end

    // Line buffer storage; writes are only ever into a bank that is not full.
    always_ff @(posedge clock) begin
        if (accept_s) begin
            mem_r[wr_sel_r][wr_col_r] <= in_word_s;
        end
    end

    // Writer: column/bank pointer and input row number tagged onto each completed bank.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            wr_col_r     <= {COL_W{1'b0}};
            wr_sel_r     <= 1'b0;
            in_row_r     <= {ROW_W{1'b0}};
            row_tag_r[0] <= {ROW_W{1'b0}};
            row_tag_r[1] <= {ROW_W{1'b0}};
        end else if (line_done_s) begin
            wr_col_r            <= {COL_W{1'b0}};
            wr_sel_r            <= ~wr_sel_r;
            row_tag_r[wr_sel_r] <= in_row_r;
            in_row_r            <= (in_row_r == ROW_LAST) ? {ROW_W{1'b0}} : in_row_r + 1'b1;
        end else if (accept_s) begin
            wr_col_r <= wr_col_r + 1'b1;
        end
    end

    // Bank-full flags; set and clear always target different banks.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            full_r <= 2'b00;
        end else begin
            full_r <= (full_r | set_mask_s) & ~clr_mask_s;
        end
    end

    // Reader FSM: walks sub_h, col, sub_v of the bank and registers one output per cycle.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            state_r         <= ST_IDLE;
            rd_sel_r        <= 1'b0;
            sub_h_r         <= SUB_ZERO;
            sub_v_r         <= SUB_ZERO;
            col_r           <= {COL_W{1'b0}};
            out_enable_r    <= 1'b0;
            out_pixels_r    <= PIX_ZERO;
            out_vcnt_r      <= {V_BITW{1'b0}};
            out_hcnt_r      <= {H_BITW{1'b0}};
            out_frame_end_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_enable_r    <= 1'b0;
                    out_frame_end_r <= 1'b0;
                    if (full_r[rd_sel_r]) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    out_enable_r    <= 1'b1;
                    out_pixels_r    <= out_val_s;
                    out_vcnt_r      <= {row_tag_r[rd_sel_r], sub_v_r};
                    out_hcnt_r      <= {col_r, sub_h_r};
                    out_frame_end_r <= last_pix_s & (row_tag_r[rd_sel_r] == ROW_LAST);
                    sub_h_r         <= sub_h_r + 1'b1;
                    if (sub_h_r == SUB_LAST) begin
                        if (col_r == COL_LAST) begin
                            col_r   <= {COL_W{1'b0}};
                            sub_v_r <= sub_v_r + 1'b1;
                        end else begin
                            col_r <= col_r + 1'b1;
                        end
                    end
                    // Chain straight into the other bank when it is already waiting.
                    if (last_pix_s) begin
                        rd_sel_r <= ~rd_sel_r;
                        if (!full_r[~rd_sel_r]) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    out_enable_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_unpooling_stream.sv
// Directed bench for unpooling_stream: MODE 0 and MODE 1 instances share one input stream,
// every output is captured and compared against a table of hand-derived output vectors.
module tb_unpooling_stream;
    localparam int IW = 4;
    localparam int IH = 2;
    localparam int FB = 8;
    localparam int UN = 1;
    localparam int SL = 1;

    logic       clock  = 1'b0;
    logic       n_rst  = 1'b0;
    logic       in_en  = 1'b0;
    logic [7:0] in_pix = 8'd0;
`ifdef UNPOOL_INDEX_EN
    logic [1:0] in_idx = 2'b11;
`endif

    always #5 clock = ~clock;

    unpooling_stream_if #(.IN_WIDTH(IW), .IN_HEIGHT(IH), .FIXED_BITW(FB), .UNITS(UN), .SCALE_LOG2(SL)) if0 ();
    unpooling_stream_if #(.IN_WIDTH(IW), .IN_HEIGHT(IH), .FIXED_BITW(FB), .UNITS(UN), .SCALE_LOG2(SL)) if1 ();

    assign if0.in_enable = in_en;
    assign if1.in_enable = in_en;
    assign if0.in_pixels = in_pix;
    assign if1.in_pixels = in_pix;
`ifdef UNPOOL_INDEX_EN
    assign if0.in_index  = in_idx;
    assign if1.in_index  = in_idx;
`endif

    unpooling_stream #(.IN_WIDTH(IW), .IN_HEIGHT(IH), .FIXED_BITW(FB), .UNITS(UN),
                       .SCALE_LOG2(SL), .MODE(0)) dut0 (.clock(clock), .n_rst(n_rst), .stream(if0));
    unpooling_stream #(.IN_WIDTH(IW), .IN_HEIGHT(IH), .FIXED_BITW(FB), .UNITS(UN),
                       .SCALE_LOG2(SL), .MODE(1)) dut1 (.clock(clock), .n_rst(n_rst), .stream(if1));

    typedef struct {
        logic [1:0] v;
        logic [2:0] h;
        logic [7:0] p0;
        logic [7:0] p1;
        logic       fe;
    } vec_t;

    typedef struct {
        logic       e0;
        logic       e1;
        logic [1:0] v0;
        logic [1:0] v1;
        logic [2:0] h0;
        logic [2:0] h1;
        logic [7:0] p0;
        logic [7:0] p1;
        logic       fe0;
        logic       fe1;
        int         cyc;
    } cap_t;

    vec_t exp_q[$];
    cap_t caps[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    logic saw_stall = 1'b0;

    function automatic logic [63:0] pack_cap(input cap_t c);
        return {34'd0, c.e0, c.e1, c.v0, c.h0, c.v1, c.h1, c.p0, c.p1, c.fe0, c.fe1};
    endfunction

    function automatic logic [63:0] pack_exp(input vec_t e);
        return {34'd0, 1'b1, 1'b1, e.v, e.h, e.v, e.h, e.p0, e.p1, e.fe, e.fe};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Expected outputs for one input row: sub_h innermost, then column, then sub_v.
    task automatic add_row(input int first, input int ir, input int nmax);
        vec_t e;
        int   cnt;
        int   p;
        cnt = 0;
        for (int sv = 0; sv < 2; sv++) begin
            for (int c = 0; c < 4; c++) begin
                for (int sh = 0; sh < 2; sh++) begin
                    if (cnt < nmax) begin
                        p    = first + c;
                        e.v  = 2'(ir * 2 + sv);
                        e.h  = 3'(c * 2 + sh);
`ifdef UNPOOL_INDEX_EN
                        e.p0 = ((sv == (3 - c) / 2) && (sh == (3 - c) % 2)) ? 8'(p) : 8'd0;
                        e.p1 = e.p0;
`else
                        e.p0 = 8'(p);
                        e.p1 = (sv == 0 && sh == 0) ? 8'(p) : 8'd0;
`endif
                        e.fe = (ir == 1 && sv == 1 && c == 3 && sh == 1);
                        exp_q.push_back(e);
                    end
                    cnt++;
                end
            end
        end
    endtask

    task automatic tick(output logic acc);
        cap_t c;
        acc = in_en && if0.in_ready;
        if (in_en && !if0.in_ready) saw_stall = 1'b1;
        @(posedge clock);
        #1;
        cyc++;
        if (acc) last_acc_cyc = cyc;
        if (if0.out_enable || if1.out_enable) begin
            c.e0  = if0.out_enable;
            c.e1  = if1.out_enable;
            c.v0  = if0.out_vcnt;
            c.v1  = if1.out_vcnt;
            c.h0  = if0.out_hcnt;
            c.h1  = if1.out_hcnt;
            c.p0  = if0.out_pixels;
            c.p1  = if1.out_pixels;
            c.fe0 = if0.out_frame_end;
            c.fe1 = if1.out_frame_end;
            c.cyc = cyc;
            caps.push_back(c);
        end
    endtask

    // Present n consecutive values with in_enable held high; stalls follow in_ready.
    task automatic feed(input int first, input int n);
        int   k;
        int   guard;
        logic a;
        k = 0;
        guard = 0;
        in_en  = 1'b1;
        in_pix = 8'(first);
`ifdef UNPOOL_INDEX_EN
        in_idx = 2'(3);
`endif
        while (k < n && guard < 500) begin
            tick(a);
            guard++;
            if (a) begin
                k++;
                in_pix = 8'(first + k);
`ifdef UNPOOL_INDEX_EN
                in_idx = 2'(3 - (k % 4));
`endif
            end
        end
        in_en = 1'b0;
        check("feed_accepted", 64'(k), 64'(n));
    endtask

    task automatic wait_caps(input int target, input int bound);
        int   guard;
        logic a;
        guard = 0;
        while (caps.size() < target && guard < bound) begin
            tick(a);
            guard++;
        end
        check("wait_outputs", 64'(caps.size()), 64'(target));
    endtask

    initial begin
        logic a;
        int   acc0;

        repeat (2) tick(a);
        check("reset_out0", 64'({if0.out_enable, if0.out_pixels, if0.out_vcnt, if0.out_hcnt, if0.out_frame_end}), 64'd0);
        check("reset_out1", 64'({if1.out_enable, if1.out_pixels, if1.out_vcnt, if1.out_hcnt, if1.out_frame_end}), 64'd0);
        check("reset_ready", 64'(if0.in_ready), 64'd0);
        n_rst = 1'b1;
        #1;
        check("ready_after_reset", 64'(if0.in_ready), 64'd1);

        // Frame 1, row 0: latency and 16 contiguous outputs.
        add_row(1, 0, 16);
        feed(1, 4);
        acc0 = last_acc_cyc;
        wait_caps(16, 50);
        if (caps.size() >= 16) begin
            check("first_out_latency", 64'(caps[0].cyc - acc0), 64'd2);
            check("row0_contiguous", 64'(caps[15].cyc - caps[0].cyc), 64'd15);
        end

        // Frame 1, row 1: closes the frame.
        add_row(5, 1, 16);
        feed(5, 4);
        wait_caps(32, 60);

        // Three rows back to back with in_enable held high.
        add_row(9, 0, 16);
        add_row(13, 1, 16);
        add_row(17, 0, 16);
        saw_stall = 1'b0;
        feed(9, 12);
        wait_caps(80, 200);
        check("stall_seen", 64'(saw_stall), 64'd1);
        if (caps.size() >= 80) begin
            check("b2b_contiguous", 64'(caps[79].cyc - caps[32].cyc), 64'd47);
        end

        // Reset in the middle of reading a row.
        add_row(21, 1, 5);
        feed(21, 4);
        wait_caps(85, 50);
        n_rst = 1'b0;
        #1;
        check("ready_in_reset", 64'(if0.in_ready), 64'd0);
        tick(a);
        check("midreset_out0", 64'({if0.out_enable, if0.out_pixels, if0.out_vcnt, if0.out_hcnt, if0.out_frame_end}), 64'd0);
        check("midreset_out1", 64'({if1.out_enable, if1.out_pixels, if1.out_vcnt, if1.out_hcnt, if1.out_frame_end}), 64'd0);
        n_rst = 1'b1;
        #1;
        check("ready_after_release", 64'(if0.in_ready), 64'd1);

        // After reset the next pixel is column 0 of row 0.
        add_row(25, 0, 16);
        feed(25, 4);
        wait_caps(101, 50);
        repeat (10) tick(a);
        check("total_outputs", 64'(caps.size()), 64'(exp_q.size()));

        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("vec%0d", i),
                  (i < caps.size()) ? pack_cap(caps[i]) : 64'd0,
                  pack_exp(exp_q[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
